// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and AXI encodings for the CPU-to-AXI4 single-beat bridge.
package cpu_axi_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    RSP     = 3'd5
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/cpu_axi_bridge_if.sv
// CPU valid/ready memory port and the AXI4 port subset used by the bridge.
interface cpu_mem_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req_valid;
  logic                    mem_req_ready;
  logic                    mem_req_wen;
  logic [ADDR_WIDTH-1:0]   mem_req_addr;
  logic [DATA_WIDTH-1:0]   mem_req_wdata;
  logic [DATA_WIDTH/8-1:0] mem_req_wstrb;
  logic                    mem_rsp_valid;
  logic                    mem_rsp_ready;
  logic [DATA_WIDTH-1:0]   mem_rsp_rdata;
  logic                    mem_rsp_err;

  modport master (
    output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
  modport slave (
    input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_rsp_ready,
    output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
  );
endinterface

interface axi4_if #(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     axi_arid;
  logic [ADDR_WIDTH-1:0]   axi_araddr;
  logic [7:0]              axi_arlen;
  logic [2:0]              axi_arsize;
  logic [1:0]              axi_arburst;
  logic                    axi_arvalid;
  logic                    axi_arready;
  logic [ID_WIDTH-1:0]     axi_rid;
  logic [DATA_WIDTH-1:0]   axi_rdata;
  logic [1:0]              axi_rresp;
  logic                    axi_rlast;
  logic                    axi_rvalid;
  logic                    axi_rready;
  logic [ID_WIDTH-1:0]     axi_awid;
  logic [ADDR_WIDTH-1:0]   axi_awaddr;
  logic [7:0]              axi_awlen;
  logic [2:0]              axi_awsize;
  logic [1:0]              axi_awburst;
  logic                    axi_awvalid;
  logic                    axi_awready;
  logic [DATA_WIDTH-1:0]   axi_wdata;
  logic [DATA_WIDTH/8-1:0] axi_wstrb;
  logic                    axi_wlast;
  logic                    axi_wvalid;
  logic                    axi_wready;
  logic [ID_WIDTH-1:0]     axi_bid;
  logic [1:0]              axi_bresp;
  logic                    axi_bvalid;
  logic                    axi_bready;

  modport master (
    output axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
           axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    input  axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
           axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );
  modport slave (
    input  axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_rready,
           axi_awid, axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
           axi_wdata, axi_wstrb, axi_wlast, axi_wvalid, axi_bready,
    output axi_arready, axi_rid, axi_rdata, axi_rresp, axi_rlast, axi_rvalid,
           axi_awready, axi_wready, axi_bid, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/cpu_axi_bridge.sv
// Turns each CPU memory request into one single-beat AXI4 read or write,
// holding the result until the CPU takes it. One transaction in flight.
module cpu_axi_bridge
  import cpu_axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int AXI_ID     = 0
) (
  input  logic     clk,
  input  logic     rst,
  cpu_mem_if.slave cpu,
  axi4_if.master   axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    aw_vld, w_vld, aw_fire, w_fire;
  logic                    unused_bits;

  assign aw_vld  = (state_q == WR_REQ) && !aw_done_q;
  assign w_vld   = (state_q == WR_REQ) && !w_done_q;
  assign aw_fire = aw_vld && axi.axi_awready;
  assign w_fire  = w_vld && axi.axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    unique case (state_q)
      IDLE: if (cpu.mem_req_valid) begin
        addr_d  = {cpu.mem_req_addr[ADDR_WIDTH-1:2], 2'b00};
        wdata_d = cpu.mem_req_wdata;
        wstrb_d = cpu.mem_req_wstrb;
        state_d = cpu.mem_req_wen ? WR_REQ : RD_ADDR;
      end
      RD_ADDR: if (axi.axi_arready) state_d = RD_DATA;
      RD_DATA: if (axi.axi_rvalid) begin
        rdata_d = axi.axi_rdata;
        err_d   = (axi.axi_rresp != AXI_RESP_OKAY) || !axi.axi_rlast;
        state_d = RSP;
      end
      WR_REQ: begin
        // AW and W retire independently; leave only once both have landed.
        aw_done_d = aw_done_q || aw_fire;
        w_done_d  = w_done_q || w_fire;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = WR_RESP;
        end
      end
      WR_RESP: if (axi.axi_bvalid) begin
        rdata_d = '0;
        err_d   = (axi.axi_bresp != AXI_RESP_OKAY);
        state_d = RSP;
      end
      RSP: if (cpu.mem_rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cpu.mem_req_ready = (state_q == IDLE);
    cpu.mem_rsp_valid = (state_q == RSP);
    axi.axi_arvalid   = (state_q == RD_ADDR);
    axi.axi_rready    = (state_q == RD_DATA);
    axi.axi_awvalid   = aw_vld;
    axi.axi_wvalid    = w_vld;
    axi.axi_bready    = (state_q == WR_RESP);
  end

  assign cpu.mem_rsp_rdata = rdata_q;
  assign cpu.mem_rsp_err   = err_q;

  assign axi.axi_arid    = ID_WIDTH'(AXI_ID);
  assign axi.axi_araddr  = addr_q;
  assign axi.axi_arlen   = 8'd0;
  assign axi.axi_arsize  = AXI_SIZE_4B;
  assign axi.axi_arburst = AXI_BURST_INCR;
  assign axi.axi_awid    = ID_WIDTH'(AXI_ID);
  assign axi.axi_awaddr  = addr_q;
  assign axi.axi_awlen   = 8'd0;
  assign axi.axi_awsize  = AXI_SIZE_4B;
  assign axi.axi_awburst = AXI_BURST_INCR;
  assign axi.axi_wdata   = wdata_q;
  assign axi.axi_wstrb   = wstrb_q;
  assign axi.axi_wlast   = 1'b1;

  // Response IDs are not checked and the word offset bits are discarded.
  assign unused_bits = ^{axi.axi_rid, axi.axi_bid, cpu.mem_req_addr[1:0]};

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
- Single-port master bridge between the custom CPU's valid/ready memory interface and an AXI4 slave port. In simulation that port is the randomly-throttled RAM wrapper.
- Converts each CPU request into exactly one single-beat AXI read or write transaction.
- Holds the returned data or status in a response register until the CPU accepts it.
- At most one transaction is outstanding at a time.

Parameters:
- ADDR_WIDTH, 30, AXI and CPU byte-address width.
- DATA_WIDTH, 32, data bus width. Only 32 is supported.
- ID_WIDTH, 4, AXI ID width.
- AXI_ID, 0, constant ID driven on AR and AW.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req_valid  in  1  CPU request valid
- mem_req_ready  out  1  bridge can accept a request
- mem_req_wen  in  1  1 = write, 0 = read
- mem_req_addr  in  ADDR_WIDTH  byte address; low 2 bits are ignored and forced to 0 on AXI
- mem_req_wdata / mem_req_wstrb  in  32 / 4  write data and byte strobes
- mem_rsp_valid  out  1  response valid
- mem_rsp_ready  in  1  CPU accepts the response
- mem_rsp_rdata  out  32  read data (0 for writes)
- mem_rsp_err  out  1  nonzero RRESP/BRESP, or RLAST=0
- axi_arid / axi_awid  out  ID_WIDTH  constant AXI_ID
- axi_araddr / axi_awaddr  out  ADDR_WIDTH  registered request address
- axi_arlen / axi_awlen  out  8  constant 0
- axi_arsize / axi_awsize  out  3  constant 3'd2
- axi_arburst / axi_awburst  out  2  constant 2'b01 (INCR)
- axi_arvalid, axi_awvalid, axi_wvalid  out  1  address and write-data valids
- axi_arready, axi_awready, axi_wready  in  1  slave readies
- axi_wdata / axi_wstrb  out  32 / 4  registered write payload
- axi_wlast  out  1  constant 1
- axi_rid / axi_rdata / axi_rresp / axi_rlast / axi_rvalid  in  ID_WIDTH / 32 / 2 / 1 / 1  read channel
- axi_rready  out  1  read-data ready
- axi_bid / axi_bresp / axi_bvalid  in  ID_WIDTH / 2 / 1  write-response channel
- axi_bready  out  1  write-response ready
- Lock, cache and prot are tied to 0 at the instantiating top level; they are not ports of this block.

Behaviour:
- State machine states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
- Reset:
  - state = IDLE.
  - All AXI valids and readies = 0; mem_rsp_valid = 0.
  - Registered address, wdata, wstrb, rdata and err = 0.
  - mem_req_ready = 1 in the first cycle after reset.
- mem_req_ready = (state == IDLE), registered-state decode only; it does not depend on mem_req_valid.
- IDLE:
  - On mem_req_valid, capture addr, wdata, wstrb and wen.
  - Go to RD_ADDR if wen = 0, else WR_REQ.
  - The corresponding AXI valid(s) rise in the next cycle (1-cycle issue latency).
- RD_ADDR:
  - axi_arvalid = 1 with a stable address until the cycle where axi_arready = 1, then go to RD_DATA.
  - arvalid never depends combinationally on arready.
- RD_DATA:
  - axi_rready = 1.
  - On axi_rvalid: capture rdata; err = (rresp != 0) | ~rlast; go to RSP.
  - rid is not checked.
- WR_REQ:
  - awvalid and wvalid are both asserted on entry.
  - Per-channel done flags aw_done and w_done. Each valid deasserts the cycle after its own handshake.
  - AW and W may complete in either order or in the same cycle.
  - Go to WR_RESP once both are done; the flags clear on that transition.
- WR_RESP:
  - axi_bready = 1.
  - On axi_bvalid: err = (bresp != 0); rdata = 0; go to RSP.
- RSP:
  - mem_rsp_valid = 1, with rdata and err held stable.
  - On mem_rsp_ready go to IDLE.
  - A new request can therefore be accepted one cycle after the response handshake; there is no bypass.
- Minimum latency with zero-wait slaves:
  - Read: request accepted at cycle N, arvalid at N+1, rvalid seen at N+2 at the earliest, mem_rsp_valid at N+3.
  - Write: response valid at N+3 at the earliest.
- rready and bready are asserted only in their own states. A stray rvalid or bvalid in any other state is ignored, not consumed.
- Synchronous reset in any state returns the block to reset values immediately. The slave is reset by the same rst, so no transaction drains.
- The address is driven with bits [1:0] = 0; wstrb is passed through unmodified.

Decomposition:
- Package cpu_axi_pkg holds:
  - State enum.
  - AXI_BURST_INCR = 2'b01.
  - AXI_SIZE_4B = 3'd2.
  - AXI_RESP_OKAY = 2'b00.
- No sub-module; the AW/W done-flag pair stays inline.
- Bench: instantiate with the RAM wrapper and drive random_mask from an LFSR.

Test Plan:
- Mask all-ones. Write 0xDEADBEEF to 0x100 with wstrb 0xF, then read 0x100 -> rsp rdata = 0xDEADBEEF, err = 0, mem_rsp_valid 3 cycles after the request is accepted.
- Hold aw_and = 0 for 5 cycles while w_and = 1 (W completes first); repeat with the order reversed -> exactly one AW and one W handshake each, one B, and the write lands correctly.
- Write 0x11223344 to 0x200, then write 0xAABBCCDD to 0x200 with wstrb 0x3 -> read 0x200 returns 0x1122CCDD.
- Hold mem_rsp_ready = 0 for 10 cycles during RSP -> rdata and err stable, mem_req_ready = 0, no new AR/AW issued.
- Assert rst during RD_DATA with arvalid already accepted -> next cycle all valids 0, mem_req_ready = 1, no mem_rsp_valid.
- 1000 random read/write requests under a random mask -> matches a scoreboard model; no AXI valid drops before its ready (assertion).
